// File: rtl/kuart_seq_pkg.sv
// Shared definitions for the kernel-UART script sequencer: opcodes, FSM states
// and script entry field layout.
package kuart_seq_pkg;

  localparam int unsigned ENTRY_W = 10;
  localparam int unsigned OP_MSB  = 9;
  localparam int unsigned OP_LSB  = 8;
  localparam int unsigned ARG_MSB = 7;
  localparam int unsigned ARG_LSB = 0;

  typedef enum logic [1:0] {
    OP_END    = 2'b00,
    OP_SEND   = 2'b01,
    OP_EXPECT = 2'b10,
    OP_WAIT   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_SEND,
    ST_EXPECT,
    ST_WAIT,
    ST_PASS,
    ST_FAIL
  } state_e;

endpackage

// File: rtl/kuart_script_mem.sv
// Script storage: DEPTH x ENTRY_W, single write port, synchronous read port.
module kuart_script_mem
  import kuart_seq_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/kuart_script_sequencer.sv
// Scripted kernel-UART console driver: walks a loaded script of SEND / EXPECT /
// WAIT / END entries and reports pass/fail with the failing script address.
module kuart_script_sequencer
  import kuart_seq_pkg::*;
#(
  parameter  int unsigned DEPTH          = 16,
  parameter  int unsigned TIMEOUT_CYCLES = 1_000_000,
  localparam int unsigned AW             = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [ENTRY_W-1:0] cfg_wdata,
  output logic [7:0]         kuart_to_cpu,
  output logic               kuart_to_cpu_valid,
  input  logic               kuart_to_cpu_ready,
  input  logic [7:0]         kuart_from_cpu,
  input  logic               kuart_from_cpu_valid,
  output logic               busy,
  output logic               finished,
  output logic               success,
  output logic [AW-1:0]      fail_pc
);

  state_e             state_q, state_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [7:0]         expect_q, expect_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;
  logic               finished_q, finished_d;
  logic               success_q, success_d;
  logic [AW-1:0]      fail_pc_q, fail_pc_d;

  logic [ENTRY_W-1:0] entry;
  op_e                op;
  logic [7:0]         arg;
  logic               handshake, log_match, timed_out, advance, fail_now;

  kuart_script_mem #(.DEPTH(DEPTH)) u_mem (
    .clk_i   (clk),
    .we_i    (cfg_we && !busy_q),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_wdata),
    .raddr_i (pc_q),
    .rdata_o (entry)
  );

  assign op        = op_e'(entry[OP_MSB:OP_LSB]);
  assign arg       = entry[ARG_MSB:ARG_LSB];
  assign handshake = tx_valid_q && kuart_to_cpu_ready;
  assign log_match = kuart_from_cpu_valid && (kuart_from_cpu == expect_q);
  assign timed_out = (cnt_q == 32'(TIMEOUT_CYCLES));

  // An entry completes here; stepping past the last address without END fails.
  assign advance  = ((state_q == ST_SEND)   && handshake) ||
                    ((state_q == ST_EXPECT) && log_match) ||
                    ((state_q == ST_WAIT)   && (cnt_q == '0));
  assign fail_now = (advance && (pc_q == AW'(DEPTH - 1))) ||
                    ((state_q == ST_EXPECT) && !log_match && timed_out);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      cnt_q      <= '0;
      expect_q   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      success_q  <= 1'b0;
      fail_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      expect_q   <= expect_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      finished_q <= finished_d;
      success_q  <= success_d;
      fail_pc_q  <= fail_pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL: if (start) state_d = ST_FETCH;
      ST_FETCH:                  state_d = ST_DECODE;
      ST_DECODE: begin
        unique case (op)
          OP_END:    state_d = ST_PASS;
          OP_SEND:   state_d = ST_SEND;
          OP_EXPECT: state_d = ST_EXPECT;
          OP_WAIT:   state_d = ST_WAIT;
        endcase
      end
      default: begin
        if (fail_now)     state_d = ST_FAIL;
        else if (advance) state_d = ST_FETCH;
      end
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    expect_d   = expect_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    finished_d = finished_q;
    success_d  = success_q;
    fail_pc_d  = fail_pc_q;
    unique case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (start) begin
          pc_d       = '0;
          busy_d     = 1'b1;
          finished_d = 1'b0;
          success_d  = 1'b0;
          fail_pc_d  = '0;
        end
      end
      ST_DECODE: begin
        unique case (op)
          OP_END: begin
            busy_d     = 1'b0;
            finished_d = 1'b1;
            success_d  = 1'b1;
          end
          OP_SEND: begin
            tx_data_d  = arg;
            tx_valid_d = 1'b1;
          end
          OP_EXPECT: begin
            expect_d = arg;
            cnt_d    = '0;
          end
          OP_WAIT: cnt_d = 32'(arg);
        endcase
      end
      ST_SEND:   if (handshake) tx_valid_d = 1'b0;
      ST_EXPECT: if (!log_match) cnt_d = cnt_q + 32'd1;
      ST_WAIT:   if (cnt_q != '0) cnt_d = cnt_q - 32'd1;
      default: ;
    endcase
    if (advance) pc_d = pc_q + AW'(1);
    if (fail_now) begin
      busy_d     = 1'b0;
      finished_d = 1'b1;
      success_d  = 1'b0;
      fail_pc_d  = pc_q;
    end
  end

  assign kuart_to_cpu       = tx_data_q;
  assign kuart_to_cpu_valid = tx_valid_q;
  assign busy               = busy_q;
  assign finished           = finished_q;
  assign success            = success_q;
  assign fail_pc            = fail_pc_q;

endmodule

// File: tb/tb_kuart_script_sequencer.sv
// Directed bench for kuart_script_sequencer: table of whole-script runs plus
// hand-written sequences for backpressure, log filtering and mid-run reset.
module tb_kuart_script_sequencer;
  import kuart_seq_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned TMO   = 100;

  logic          clk = 1'b0;
  logic          reset, start, cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [9:0]    cfg_wdata;
  logic [7:0]    kuart_to_cpu;
  logic          kuart_to_cpu_valid, kuart_to_cpu_ready;
  logic [7:0]    kuart_from_cpu;
  logic          kuart_from_cpu_valid;
  logic          busy, finished, success;
  logic [AW-1:0] fail_pc;

  int         errors = 0;
  int         checks = 0;
  int         sends  = 0;
  int         base;
  int         k;
  logic [7:0] last_tx = 8'h00;
  string      log_str;

  always #5 clk = ~clk;

  kuart_script_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .cfg_we               (cfg_we),
    .cfg_addr             (cfg_addr),
    .cfg_wdata            (cfg_wdata),
    .kuart_to_cpu         (kuart_to_cpu),
    .kuart_to_cpu_valid   (kuart_to_cpu_valid),
    .kuart_to_cpu_ready   (kuart_to_cpu_ready),
    .kuart_from_cpu       (kuart_from_cpu),
    .kuart_from_cpu_valid (kuart_from_cpu_valid),
    .busy                 (busy),
    .finished             (finished),
    .success              (success),
    .fail_pc              (fail_pc)
  );

  always @(posedge clk) begin
    if (kuart_to_cpu_valid && kuart_to_cpu_ready) begin
      sends   <= sends + 1;
      last_tx <= kuart_to_cpu;
    end
  end

  typedef struct {
    string      name;
    logic [9:0] e0, e1, e2, e3, fill;
    logic       log_en;
    logic [7:0] log_byte;
    logic       exp_success;
    logic [3:0] exp_fail_pc;
    int         exp_cycles;
    int         exp_sends;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [9:0] ent(input op_e op, input logic [7:0] a);
    return {op, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_script(input logic [9:0] e0, e1, e2, e3, fill);
    for (int unsigned a = 0; a < DEPTH; a++) begin
      cfg_we    = 1'b1;
      cfg_addr  = AW'(a);
      cfg_wdata = (a == 0) ? e0 : (a == 1) ? e1 : (a == 2) ? e2 : (a == 3) ? e3 : fill;
      @(negedge clk);
    end
    cfg_we = 1'b0;
  endtask

  // k counts clock edges after the edge that samples start.
  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_clears_finished", 32'(finished), 32'd0);
    chk("start_clears_fail_pc", 32'(fail_pc), 32'd0);
  endtask

  task automatic wait_done(input int budget);
    while (!finished && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("finished_within_budget", 32'(finished), 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    while (!kuart_to_cpu_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("valid_seen", 32'(kuart_to_cpu_valid), 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    kuart_to_cpu_ready = 1'b0; kuart_from_cpu = '0; kuart_from_cpu_valid = 1'b0;

    vecs[0] = '{"send_end",   ent(OP_SEND, 8'h72), ent(OP_END, 8'h00), ent(OP_END, 8'h00),
                ent(OP_END, 8'h00), ent(OP_END, 8'h00), 1'b0, 8'h00, 1'b1, 4'd0, 5, 1, 8'h72};
    vecs[1] = '{"wait0_end",  ent(OP_WAIT, 8'h00), ent(OP_END, 8'h00), ent(OP_END, 8'h00),
                ent(OP_END, 8'h00), ent(OP_END, 8'h00), 1'b0, 8'h00, 1'b1, 4'd0, 5, 0, 8'h00};
    vecs[2] = '{"wait5_end",  ent(OP_WAIT, 8'h05), ent(OP_END, 8'h00), ent(OP_END, 8'h00),
                ent(OP_END, 8'h00), ent(OP_END, 8'h00), 1'b0, 8'h00, 1'b1, 4'd0, 10, 0, 8'h00};
    vecs[3] = '{"two_sends",  ent(OP_SEND, 8'h41), ent(OP_SEND, 8'h42), ent(OP_END, 8'h00),
                ent(OP_END, 8'h00), ent(OP_END, 8'h00), 1'b0, 8'h00, 1'b1, 4'd0, 8, 2, 8'h42};
    vecs[4] = '{"expect_hit", ent(OP_EXPECT, 8'h2E), ent(OP_END, 8'h00), ent(OP_END, 8'h00),
                ent(OP_END, 8'h00), ent(OP_END, 8'h00), 1'b1, 8'h2E, 1'b1, 4'd0, 5, 0, 8'h00};
    vecs[5] = '{"expect_tmo", ent(OP_EXPECT, 8'h2E), ent(OP_END, 8'h00), ent(OP_END, 8'h00),
                ent(OP_END, 8'h00), ent(OP_END, 8'h00), 1'b0, 8'h00, 1'b0, 4'd0, 103, 0, 8'h00};
    vecs[6] = '{"wait_expect_tmo", ent(OP_WAIT, 8'h02), ent(OP_EXPECT, 8'h55), ent(OP_END, 8'h00),
                ent(OP_END, 8'h00), ent(OP_END, 8'h00), 1'b1, 8'h54, 1'b0, 4'd1, 108, 0, 8'h00};
    vecs[7] = '{"end_only",   ent(OP_END, 8'h00), ent(OP_END, 8'h00), ent(OP_END, 8'h00),
                ent(OP_END, 8'h00), ent(OP_END, 8'h00), 1'b0, 8'h00, 1'b1, 4'd0, 2, 0, 8'h00};
    vecs[8] = '{"no_end",     ent(OP_WAIT, 8'h00), ent(OP_WAIT, 8'h00), ent(OP_WAIT, 8'h00),
                ent(OP_WAIT, 8'h00), ent(OP_WAIT, 8'h00), 1'b0, 8'h00, 1'b0, 4'd15, 48, 0, 8'h00};
    vecs[9] = '{"mixed",      ent(OP_SEND, 8'hA5), ent(OP_WAIT, 8'h01), ent(OP_SEND, 8'h5A),
                ent(OP_END, 8'h00), ent(OP_END, 8'h00), 1'b0, 8'h00, 1'b1, 4'd0, 12, 2, 8'h5A};

    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(kuart_to_cpu_valid), 32'd0);
    chk("rst_data", 32'(kuart_to_cpu), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_finished", 32'(finished), 32'd0);
    chk("rst_success", 32'(success), 32'd0);
    chk("rst_fail_pc", 32'(fail_pc), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Whole-script runs with ready held high.
    for (int i = 0; i < 10; i++) begin
      kuart_to_cpu_ready   = 1'b1;
      kuart_from_cpu_valid = vecs[i].log_en;
      kuart_from_cpu       = vecs[i].log_byte;
      load_script(vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].fill);
      base = sends;
      start_run();
      wait_done(vecs[i].exp_cycles + 20);
      chk({vecs[i].name, "_cycles"}, 32'(k), 32'(vecs[i].exp_cycles));
      chk({vecs[i].name, "_success"}, 32'(success), 32'(vecs[i].exp_success));
      chk({vecs[i].name, "_fail_pc"}, 32'(fail_pc), 32'(vecs[i].exp_fail_pc));
      chk({vecs[i].name, "_busy"}, 32'(busy), 32'd0);
      chk({vecs[i].name, "_sends"}, 32'(sends - base), 32'(vecs[i].exp_sends));
      if (vecs[i].exp_sends > 0)
        chk({vecs[i].name, "_last_tx"}, 32'(last_tx), 32'(vecs[i].exp_last));
      kuart_from_cpu_valid = 1'b0;
      @(negedge clk);
    end

    // Backpressure: ready low for 4 valid cycles, data must hold.
    load_script(ent(OP_SEND, 8'h72), ent(OP_END, 8'h00), ent(OP_END, 8'h00),
                ent(OP_END, 8'h00), ent(OP_END, 8'h00));
    kuart_to_cpu_ready = 1'b0;
    base = sends;
    start_run();
    wait_valid(10);
    chk("bp_valid_rise_cycle", 32'(k), 32'd2);
    for (int j = 0; j < 4; j++) begin
      chk("bp_hold_valid", 32'(kuart_to_cpu_valid), 32'd1);
      chk("bp_hold_data", 32'(kuart_to_cpu), 32'h72);
      @(negedge clk);
      k++;
    end
    kuart_to_cpu_ready = 1'b1;
    @(negedge clk);
    k++;
    chk("bp_valid_drop", 32'(kuart_to_cpu_valid), 32'd0);
    wait_done(40);
    chk("bp_cycles", 32'(k), 32'd9);
    chk("bp_success", 32'(success), 32'd1);
    chk("bp_single_transfer", 32'(sends - base), 32'd1);

    // Log filtering: only '.' satisfies the EXPECT.
    log_str = "ram: 12K.";
    load_script(ent(OP_SEND, 8'h72), ent(OP_EXPECT, 8'h2E), ent(OP_END, 8'h00),
                ent(OP_END, 8'h00), ent(OP_END, 8'h00));
    kuart_to_cpu_ready = 1'b1;
    base = sends;
    start_run();
    kuart_from_cpu_valid = 1'b1;
    kuart_from_cpu       = log_str[0];
    for (int i = 1; i < 9; i++) begin
      @(negedge clk);
      k++;
      kuart_from_cpu = log_str[i];
    end
    @(negedge clk);
    k++;
    kuart_from_cpu_valid = 1'b0;
    chk("log_not_done_early", 32'(finished), 32'd0);
    wait_done(40);
    chk("log_cycles", 32'(k), 32'd11);
    chk("log_success", 32'(success), 32'd1);
    chk("log_sends", 32'(sends - base), 32'd1);

    // Reset while SEND is stalled, then a dropped write on the rerun.
    load_script(ent(OP_SEND, 8'h33), ent(OP_END, 8'h00), ent(OP_END, 8'h00),
                ent(OP_END, 8'h00), ent(OP_END, 8'h00));
    kuart_to_cpu_ready = 1'b0;
    start_run();
    wait_valid(10);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(kuart_to_cpu_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data", 32'(kuart_to_cpu), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    base = sends;
    start_run();
    @(negedge clk);
    k++;
    chk("busy_write_busy", 32'(busy), 32'd1);
    cfg_we    = 1'b1;
    cfg_addr  = 4'd1;
    cfg_wdata = ent(OP_SEND, 8'h99);
    @(negedge clk);
    k++;
    cfg_we = 1'b0;
    kuart_to_cpu_ready = 1'b1;
    wait_done(40);
    chk("busy_write_success", 32'(success), 32'd1);
    chk("busy_write_sends", 32'(sends - base), 32'd1);
    chk("busy_write_last_tx", 32'(last_tx), 32'h33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
